// File: rtl/m_cache_refill.sv
// m_cache_refill: miss refill and invalidation sweep controller
// for a 32-line direct-mapped cache (58-bit lines: v, tag, word).
module m_cache_refill (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_req,
  input  logic [31:0] w_adr,
  input  logic        w_hit,
  input  logic        w_flush,
  output logic        w_stall,
  output logic        w_mem_req,
  output logic [31:0] w_mem_adr,
  input  logic        w_mem_ack,
  input  logic [31:0] w_mem_rdata,
  output logic        w_we,
  output logic [4:0]  w_wadr,
  output logic [57:0] w_wd,
  output logic [31:0] w_miss_cnt
);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_MREQ,
    S_FILL
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lat_adr_q, lat_adr_d;
  logic [31:0] lat_data_q, lat_data_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [4:0]  fcnt_q, fcnt_d;
  logic        miss;

  assign miss = w_req & ~w_hit;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= S_FLUSH;
      lat_adr_q  <= '0;
      lat_data_q <= '0;
      miss_cnt_q <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      lat_adr_q  <= lat_adr_d;
      lat_data_q <= lat_data_d;
      miss_cnt_q <= miss_cnt_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_adr_d  = lat_adr_q;
    lat_data_d = lat_data_q;
    miss_cnt_d = miss_cnt_q;
    fcnt_d     = fcnt_q;
    w_we       = 1'b0;
    w_wadr     = '0;
    w_wd       = '0;
    w_mem_req  = 1'b0;
    w_mem_adr  = '0;
    unique case (state_q)
      S_FLUSH: begin
        w_we   = 1'b1;
        w_wadr = fcnt_q;
        fcnt_d = fcnt_q + 5'd1;
        if (fcnt_q == 5'd31) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end
      end
      S_IDLE: begin
        // flush wins; a coincident miss is re-detected afterwards
        if (w_flush) begin
          state_d = S_FLUSH;
          fcnt_d  = '0;
        end else if (miss) begin
          lat_adr_d  = w_adr;
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = S_MREQ;
        end
      end
      S_MREQ: begin
        w_mem_req = 1'b1;
        w_mem_adr = {lat_adr_q[31:2], 2'b00};
        if (w_mem_ack) begin
          lat_data_d = w_mem_rdata;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        w_we    = 1'b1;
        w_wadr  = lat_adr_q[6:2];
        w_wd    = {1'b1, lat_adr_q[31:7], lat_data_q};
        state_d = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  assign w_stall = (state_q != S_IDLE) | miss |
                   ((state_q == S_IDLE) & w_flush);

  assign w_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_m_cache_refill.sv
// tb_m_cache_refill: directed + random miss traffic against a
// behavioural cache/refill model.
module tb_m_cache_refill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] rdata = '0;
  logic        hit;
  logic        stall, mreq, we;
  logic [31:0] madr, mcnt;
  logic [4:0]  wadr;
  logic [57:0] wd;

  int checks = 0;
  int errors = 0;

  logic [57:0] env_cache [32];
  bit          refv [32];
  logic [24:0] reftag [32];
  logic [31:0] exp_cnt = '0;
  logic [31:0] hist [$];

  m_cache_refill dut (
    .w_clk       (clk),
    .w_rst_n     (rst_n),
    .w_req       (req),
    .w_adr       (adr),
    .w_hit       (hit),
    .w_flush     (flush),
    .w_stall     (stall),
    .w_mem_req   (mreq),
    .w_mem_adr   (madr),
    .w_mem_ack   (ack),
    .w_mem_rdata (rdata),
    .w_we        (we),
    .w_wadr      (wadr),
    .w_wd        (wd),
    .w_miss_cnt  (mcnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (we) env_cache[wadr] <= wd;

  assign hit = req && (env_cache[adr[6:2]][57] === 1'b1) &&
               (env_cache[adr[6:2]][56:32] === adr[31:7]);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flush();
    for (int i = 0; i < 32; i++) begin
      chk("fl_we", 64'(we), 1);
      chk("fl_wadr", 64'(wadr), 64'(i));
      chk("fl_wd", 64'(wd), 0);
      chk("fl_stall", 64'(stall), 1);
      chk("fl_mreq", 64'(mreq), 0);
      if (i < 31) begin
        @(negedge clk);
        #1;
      end
    end
    for (int i = 0; i < 32; i++) refv[i] = 1'b0;
  endtask

  task automatic do_miss(input logic [31:0] a, input int lat,
                         input logic [31:0] d);
    logic [57:0] line;
    req = 1'b1;
    adr = a;
    #1;
    exp_cnt++;
    chk("m_stall0", 64'(stall), 1);
    chk("m_mreq0", 64'(mreq), 0);
    chk("m_we0", 64'(we), 0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      ack = (k == lat);
      rdata = ack ? d : $urandom;
      #1;
      chk("m_mreq", 64'(mreq), 1);
      chk("m_madr", 64'(madr), 64'({a[31:2], 2'b00}));
      chk("m_stall", 64'(stall), 1);
      chk("m_we", 64'(we), 0);
    end
    @(negedge clk);
    ack = 1'b0;
    #1;
    line = {1'b1, a[31:7], d};
    chk("f_we", 64'(we), 1);
    chk("f_wadr", 64'(wadr), 64'(a[6:2]));
    chk("f_wd", 64'(wd), 64'(line));
    chk("f_stall", 64'(stall), 1);
    chk("f_mreq", 64'(mreq), 0);
    refv[a[6:2]] = 1'b1;
    reftag[a[6:2]] = a[31:7];
    @(negedge clk);
    #1;
    chk("i_stall", 64'(stall), 0);
    chk("i_cnt", 64'(mcnt), 64'(exp_cnt));
    req = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] a);
    req = 1'b1;
    adr = a;
    #1;
    chk("h_stall", 64'(stall), 0);
    chk("h_mreq", 64'(mreq), 0);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("h_cnt", 64'(mcnt), 64'(exp_cnt));
    chk("h_mreq1", 64'(mreq), 0);
    chk("h_we", 64'(we), 0);
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return refv[a[6:2]] && (reftag[a[6:2]] == a[31:7]);
  endfunction

  initial begin
    logic [31:0] a;
    // reset state
    @(negedge clk);
    #1;
    chk("rst_we", 64'(we), 1);
    chk("rst_wadr", 64'(wadr), 0);
    chk("rst_wd", 64'(wd), 0);
    chk("rst_stall", 64'(stall), 1);
    chk("rst_mreq", 64'(mreq), 0);
    chk("rst_madr", 64'(madr), 0);
    chk("rst_cnt", 64'(mcnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_flush();
    @(negedge clk);
    #1;
    chk("post_we", 64'(we), 0);
    chk("post_stall", 64'(stall), 0);

    // single miss, L=1
    @(negedge clk);
    do_miss(32'h0000_0084, 1, 32'hDEADBEEF);
    chk("l1_cnt", 64'(mcnt), 1);
    @(negedge clk);
    do_hit(32'h0000_0084);

    // spurious ack in IDLE
    @(negedge clk);
    ack = 1'b1;
    rdata = $urandom;
    #1;
    chk("sp_mreq", 64'(mreq), 0);
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("sp_we", 64'(we), 0);
    chk("sp_stall", 64'(stall), 0);
    chk("sp_cnt", 64'(mcnt), 64'(exp_cnt));

    // slow memory, L=5, unaligned low bits
    @(negedge clk);
    do_miss(32'h1234_567B, 5, $urandom);

    // flush and miss together
    @(negedge clk);
    flush = 1'b1;
    req = 1'b1;
    adr = 32'h0000_0200;
    #1;
    chk("fm_stall", 64'(stall), 1);
    chk("fm_cnt0", 64'(mcnt), 64'(exp_cnt));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fm_cnt1", 64'(mcnt), 64'(exp_cnt));
    chk_flush();
    @(negedge clk);
    do_miss(32'h0000_0200, 2, $urandom);

    // randomized traffic
    for (int n = 0; n < 16; n++) begin
      if (hist.size() > 0 && ($urandom % 3) == 0)
        a = hist[$urandom_range(0, hist.size() - 1)];
      else
        a = $urandom;
      @(negedge clk);
      if (model_hit(a)) begin
        do_hit(a);
      end else begin
        do_miss(a, $urandom_range(1, 5), $urandom);
        hist.push_back(a);
      end
    end

    // async reset two cycles into MREQ
    @(negedge clk);
    req = 1'b1;
    adr = 32'h0000_0ABC;
    #1;
    chk("rm_stall", 64'(stall), 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rm_mreq", 64'(mreq), 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk("rm_mreq0", 64'(mreq), 0);
    chk("rm_madr0", 64'(madr), 0);
    chk("rm_cnt0", 64'(mcnt), 0);
    chk("rm_we", 64'(we), 1);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk_flush();
    @(negedge clk);
    #1;
    chk("rm_idle", 64'(stall), 0);

    // counter wrap
    @(negedge clk);
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    chk("wr_pre", 64'(mcnt), 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    release dut.miss_cnt_q;
    do_miss(32'h0000_0F00, 1, $urandom);
    chk("wr_zero", 64'(mcnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
